// File: rtl/tiny16_pkg.sv
// Shared definitions for the display output path: UART states, frame
// constants and the ASCII offsets used by hex mode (DSP_UART_HEX_EN).
package tiny16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int          UART_DATA_BITS = 8;
  localparam logic        UART_START     = 1'b0;
  localparam logic        UART_STOP      = 1'b1;

  localparam logic [7:0]  HEX_DIGIT_OFS  = 8'h30;  // '0' - 0
  localparam logic [7:0]  HEX_ALPHA_OFS  = 8'h37;  // 'A' - 10

endpackage

// File: rtl/dsp_uart_out_if.sv
// Display-path bundle between the controller/datapath and dsp_uart_out.
// master = controller side, slave = the UART output block.
interface dsp_uart_out_if;
  logic [15:0] bus_in;
  logic        dsp_in_en;
  logic        ovf_clr;
  logic        tx;
  logic        busy;
  logic        empty;
  logic        full;
  logic        overflow;

  modport master (
    output bus_in, dsp_in_en, ovf_clr,
    input  tx, busy, empty, full, overflow
  );

  modport slave (
    input  bus_in, dsp_in_en, ovf_clr,
    output tx, busy, empty, full, overflow
  );
endinterface

// File: rtl/uart_tx_byte.sv
// One 8N1 byte transmitter (LSB first). Holds the baud counter and the
// START/DATA/STOP shifter. 'ready' is high in IDLE and on the last cycle of
// STOP, so a byte loaded then follows with no idle gap.
module uart_tx_byte
  import tiny16_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  uart_state_e state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_q, tx_n;
  logic        wrap;

  assign wrap = (cnt == DIV_LAST);
  assign tx   = tx_q;

  // State register; tx comes straight from a flop so the line never glitches.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= UART_STOP;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  // Next-state: tx only changes on a baud wrap or on entering START.
  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_n = state;
    cnt_n   = wrap ? '0 : cnt + 16'd1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        cnt_n = '0;
        if (load) begin
          state_n = START;
          shreg_n = data;
          tx_n    = UART_START;
        end
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            state_n = STOP;
            tx_n    = UART_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shreg[bit_n];
          end
        end
      end
      STOP: begin
        if (wrap) begin
          ready = 1'b1;
          if (load) begin
            state_n = START;
            shreg_n = data;
            tx_n    = UART_START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/dsp_uart_out.sv
// Display output block: captures bus_in on each dsp_in_en strobe into a
// small FIFO and sends every word over UART, high byte first.
// Optional macro DSP_UART_HEX_EN: send each word as 4 uppercase ASCII hex
// characters (MS nibble first) instead of 2 raw bytes.
module dsp_uart_out
  import tiny16_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  dsp_uart_out_if.slave  io
);

  localparam int AW = $clog2(DEPTH);
`ifdef DSP_UART_HEX_EN
  localparam int IW = 2;  // 4 characters per word
`else
  localparam int IW = 1;  // 2 bytes per word
`endif
  localparam logic [IW-1:0] LAST_BYTE = '1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   hold, head;
  logic [IW-1:0] byte_idx;
  logic          busy_q, overflow_q;
  logic          full, empty, ready, pop, push, next_byte, load;
  logic [7:0]    load_data;

  // Character/byte number idx of a word as it goes on the wire.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic [IW-1:0] idx);
`ifdef DSP_UART_HEX_EN
    logic [3:0] nib;
    nib = 4'(word >> (4'd12 - {idx, 2'b00}));
    return (nib < 4'd10) ? HEX_DIGIT_OFS + 8'(nib) : HEX_ALPHA_OFS + 8'(nib);
`else
    return idx ? word[7:0] : word[15:8];
`endif
  endfunction

  assign head      = mem[rd_ptr];
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pop       = !busy_q && !empty && ready;
  assign push      = io.dsp_in_en && (!full || pop);
  assign next_byte = busy_q && ready && (byte_idx != LAST_BYTE);
  assign load      = pop || next_byte;
  assign load_data = pop ? pick_byte(head, '0) : pick_byte(hold, byte_idx + IW'(1));

  assign io.busy     = busy_q;
  assign io.empty    = empty;
  assign io.full     = full;
  assign io.overflow = overflow_q;

  // FIFO storage write.
  // NOTE: the word array has no reset; count says which entries are valid, and it can map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io.bus_in;
  end

  // FIFO pointers, occupancy and sticky overflow (a set beats a same-cycle clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (io.dsp_in_en && !push) overflow_q <= 1'b1;
      else if (io.ovf_clr)       overflow_q <= 1'b0;
    end
  end

  // Word sequencing: pop into hold, step through its bytes, drop busy after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      byte_idx <= '0;
      busy_q   <= 1'b0;
    end else if (pop) begin
      hold     <= head;
      byte_idx <= '0;
      busy_q   <= 1'b1;
    end else if (next_byte) begin
      byte_idx <= byte_idx + IW'(1);
    end else if (busy_q && ready) begin
      busy_q   <= 1'b0;
    end
  end

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (load_data),
    .ready (ready),
    .tx    (io.tx)
  );

endmodule

// File: tb/tb_dsp_uart_out.sv
// Self-checking bench for dsp_uart_out (CLK_DIV=4, DEPTH=4). Works in raw
// mode and with DSP_UART_HEX_EN defined.
module tb_dsp_uart_out;

  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef DSP_UART_HEX_EN
  localparam int NB = 4;
`else
  localparam int NB = 2;
`endif
  localparam int OCC = 10 * D * NB;  // cycles busy per word

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_uart_out_if io ();

  dsp_uart_out #(.CLK_DIV(D), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mq[$];
  int          m_timer;
  logic [15:0] m_word;
  logic        m_ovf;
  bit          m_pop, m_set;
  int          m_size;

  function automatic logic [7:0] model_byte(input logic [15:0] w, input int k);
    int n;
    if (NB == 4) begin
      n = (w >> (12 - 4 * k)) & 15;
      return (n < 10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
    end
    return (k == 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic model_tx();
    int el, k, pos;
    logic [7:0] b;
    if (m_timer == 0) return 1'b1;
    el  = OCC - m_timer;
    k   = el / (10 * D);
    pos = (el % (10 * D)) / D;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    b = model_byte(m_word, k);
    return b[pos-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_timer = 0;
      m_word  = '0;
      m_ovf   = 1'b0;
    end else begin
      m_size = mq.size();
      m_pop  = (m_timer == 0) && (m_size > 0);
      m_set  = 1'b0;
      if (m_timer > 0) m_timer--;
      if (m_pop) begin
        m_word  = mq.pop_front();
        m_timer = OCC;
      end
      if (io.dsp_in_en) begin
        if (m_size < DEPTH || m_pop) mq.push_back(io.bus_in);
        else m_set = 1'b1;
      end
      if (io.ovf_clr) m_ovf = 1'b0;
      if (m_set)      m_ovf = 1'b1;
    end
  end

  // Compare every cycle outside reset, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("tx",       io.tx,       model_tx());
      check("busy",     io.busy,     m_timer != 0);
      check("empty",    io.empty,    mq.size() == 0);
      check("full",     io.full,     mq.size() == DEPTH);
      check("overflow", io.overflow, m_ovf);
    end
  end

  // ---------------- UART receiver on the DUT line ----------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  bit         rx_act;
  int         rx_cnt, rx_rel, rx_idx;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_act = 1'b0;
      rx_cnt = 0;
    end else if (!rx_act) begin
      if (io.tx == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      rx_rel = rx_cnt - D / 2;
      if (rx_rel >= 0 && rx_rel % D == 0) begin
        rx_idx = rx_rel / D;
        if (rx_idx >= 1 && rx_idx <= 8) begin
          rx_sh[rx_idx-1] = io.tx;
        end else if (rx_idx == 9) begin
          check("rx_stop_bit", io.tx, 1'b1);
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [15:0] v, input logic en, input logic clr);
    @(negedge clk);
    io.bus_in    = v;
    io.dsp_in_en = en;
    io.ovf_clr   = clr;
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check(name, rx_q[i], exp[i]);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(io.empty && !io.busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < limit, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_b[$];
  logic [15:0] w1;
  string hex_s;
  int n;

  initial begin
    io.bus_in    = '0;
    io.dsp_in_en = 1'b0;
    io.ovf_clr   = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tx",       io.tx,       1'b1);
    check("rst_busy",     io.busy,     1'b0);
    check("rst_empty",    io.empty,    1'b1);
    check("rst_full",     io.full,     1'b0);
    check("rst_overflow", io.overflow, 1'b0);
    #1 rst = 1'b0;

    // Single word
`ifdef DSP_UART_HEX_EN
    w1 = 16'h1A2F;
`else
    w1 = 16'h4142;
`endif
    drive(w1, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0);
    n = 0;
    while (!io.busy && n < 20) begin @(negedge clk); n++; end
    check("busy_rise_timeout", n < 20, 1'b1);
    check("empty_after_pop", io.empty, 1'b1);
    n = 0;
    while (io.busy && n < 1000) begin @(negedge clk); n++; end
`ifdef DSP_UART_HEX_EN
    check("busy_cycles", n, 160);
    exp_b = '{8'h31, 8'h41, 8'h32, 8'h46};
`else
    check("busy_cycles", n, 80);
    exp_b = '{8'h41, 8'h42};
`endif
    repeat (20) @(negedge clk);
    check_rx("single_word", exp_b);
    rx_q.delete();

    // Fill from idle: word 1 pops on the 2nd edge, so all 5 fit
    for (int i = 1; i <= 5; i++) drive(16'(i), 1'b1, 1'b0);
    @(negedge clk);
    check("fill_full",     io.full,     1'b1);
    check("fill_overflow", io.overflow, 1'b0);
    io.bus_in = 16'h0066;                                   // 6th strobe, dropped
    @(negedge clk);
    check("ovf_set",      io.overflow, 1'b1);
    io.dsp_in_en = 1'b0; io.ovf_clr = 1'b1;                 // clear alone
    @(negedge clk);
    check("ovf_clr_alone", io.overflow, 1'b0);
    io.dsp_in_en = 1'b1; io.bus_in = 16'h0077;              // clear + overflowing strobe
    @(negedge clk);
    check("ovf_set_wins", io.overflow, 1'b1);
    io.dsp_in_en = 1'b0;
    @(negedge clk);
    check("ovf_clr_again", io.overflow, 1'b0);
    io.ovf_clr = 1'b0;

    // Push while full on the exact pop cycle
    n = 0;
    while (!(!io.busy && io.full) && n < 1000) begin @(negedge clk); n++; end
    check("pop_slot_timeout", n < 1000, 1'b1);
    io.bus_in = 16'hBEEF; io.dsp_in_en = 1'b1;
    @(negedge clk);
    io.dsp_in_en = 1'b0;
    check("beef_full",     io.full,     1'b1);
    check("beef_overflow", io.overflow, 1'b0);
    wait_idle(4000);
    repeat (20) @(negedge clk);
`ifdef DSP_UART_HEX_EN
    hex_s = "00010002000300040005BEEF";
    exp_b.delete();
    for (int i = 0; i < hex_s.len(); i++) exp_b.push_back(hex_s[i]);
`else
    exp_b = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
              8'h00, 8'h04, 8'h00, 8'h05, 8'hBE, 8'hEF};
`endif
    check_rx("fill_stream", exp_b);
    rx_q.delete();

    // Reset during bit 3 of byte 0 (that bit is 0 in both modes for 0x5252)
    drive(16'h5252, 1'b1, 1'b0);
    drive(16'h1234, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b0);
    check("pre_rst_busy", io.busy, 1'b1);
    repeat (17) @(negedge clk);
    check("pre_rst_tx", io.tx, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx",    io.tx,    1'b1);
    check("async_rst_busy",  io.busy,  1'b0);
    check("async_rst_empty", io.empty, 1'b1);
    check("async_rst_full",  io.full,  1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (150) @(negedge clk);
    check("no_residual_frame", rx_q.size(), 0);
    check("post_rst_empty",    io.empty,    1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
